// File: rtl/mem_access_if.sv
// Bus bundle between the LC3 pipeline/data memory (master) and mem_access_unit (slave).
interface mem_access_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
);
   logic              start;
   logic [3:0]        opcode;
   logic [ADDR_W-1:0] eff_addr;
   logic [DATA_W-1:0] st_data;
   logic              dmem_req;
   logic              dmem_we;
   logic [ADDR_W-1:0] dmem_addr;
   logic [DATA_W-1:0] dmem_din;
   logic [DATA_W-1:0] dmem_dout;
   logic              dmem_ack;
   logic [DATA_W-1:0] mem_out;
   logic              complete_data;
   logic              busy;
   logic [1:0]        mem_state;
   logic              mem_err;

   modport master (
      output start, opcode, eff_addr, st_data, dmem_dout, dmem_ack,
      input  dmem_req, dmem_we, dmem_addr, dmem_din, mem_out, complete_data,
             busy, mem_state, mem_err
   );

   modport slave (
      input  start, opcode, eff_addr, st_data, dmem_dout, dmem_ack,
      output dmem_req, dmem_we, dmem_addr, dmem_din, mem_out, complete_data,
             busy, mem_state, mem_err
   );
endinterface

// File: rtl/mem_access_unit.sv
// LC3 data-memory access stage: sequences LD/LDR/LDI/ST/STR/STI over a req/ack bus.
// Define MEM_TIMEOUT_EN to abort a transaction left unacknowledged for TIMEOUT_CYCLES cycles.
module mem_access_unit #(
   parameter int ADDR_W         = 16,
   parameter int DATA_W         = 16,
   parameter int TIMEOUT_CYCLES = 64
) (
   input logic         clk,
   input logic         rst,
   mem_access_if.slave bus
);
   localparam logic [3:0] OP_LD  = 4'b0010;
   localparam logic [3:0] OP_LDR = 4'b0110;
   localparam logic [3:0] OP_LDI = 4'b1010;
   localparam logic [3:0] OP_ST  = 4'b0011;
   localparam logic [3:0] OP_STR = 4'b0111;
   localparam logic [3:0] OP_STI = 4'b1011;

   // Encoding is shared with the controller's stall logic.
   typedef enum logic [1:0] {
      ST_READ     = 2'd0,
      ST_INDIRECT = 2'd1,
      ST_WRITE    = 2'd2,
      ST_IDLE     = 2'd3
   } state_t;

   state_t            state_r;
   logic              req_r;
   logic              we_r;
   logic              complete_r;
   logic              busy_r;
   logic              err_r;
   logic              ind_store_r;
   logic [ADDR_W-1:0] addr_r;
   logic [DATA_W-1:0] din_r;
   logic [DATA_W-1:0] mem_out_r;
   logic              ack_s;
   logic              timeout_s;

   assign ack_s = req_r & bus.dmem_ack;

`ifdef MEM_TIMEOUT_EN
   localparam int TCNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_CYCLES - 1);

   logic [TCNT_W-1:0] tcnt_r;

   assign timeout_s = req_r & ~bus.dmem_ack & (tcnt_r == TCNT_LAST);

   // Wait counter restarts whenever no request is open or one has just been accepted.
   always_ff @(posedge clk) begin
      if (rst) begin
         tcnt_r <= {TCNT_W{1'b0}};
      end else if (!req_r || ack_s || timeout_s) begin
         tcnt_r <= {TCNT_W{1'b0}};
      end else begin
         tcnt_r <= tcnt_r + TCNT_W'(1);
      end
   end
`else
   assign timeout_s = 1'b0;
`endif

   // Transaction sequencer; every bus-facing output is produced by this register set.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         req_r       <= 1'b0;
         we_r        <= 1'b0;
         addr_r      <= {ADDR_W{1'b0}};
         din_r       <= {DATA_W{1'b0}};
         mem_out_r   <= {DATA_W{1'b0}};
         complete_r  <= 1'b0;
         busy_r      <= 1'b0;
         err_r       <= 1'b0;
         ind_store_r <= 1'b0;
      end else begin
         complete_r <= 1'b0;
         err_r      <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (bus.start) begin
                  case (bus.opcode)
                     OP_LD, OP_LDR: begin
                        state_r <= ST_READ;
                        req_r   <= 1'b1;
                        we_r    <= 1'b0;
                        addr_r  <= bus.eff_addr;
                        busy_r  <= 1'b1;
                     end
                     OP_ST, OP_STR: begin
                        state_r <= ST_WRITE;
                        req_r   <= 1'b1;
                        we_r    <= 1'b1;
                        addr_r  <= bus.eff_addr;
                        din_r   <= bus.st_data;
                        busy_r  <= 1'b1;
                     end
                     OP_LDI, OP_STI: begin
                        state_r     <= ST_INDIRECT;
                        req_r       <= 1'b1;
                        we_r        <= 1'b0;
                        addr_r      <= bus.eff_addr;
                        din_r       <= bus.st_data;
                        ind_store_r <= bus.opcode[0];
                        busy_r      <= 1'b1;
                     end
                     default: begin
                     end
                  endcase
               end
            end
            ST_INDIRECT: begin
               if (timeout_s) begin
                  state_r    <= ST_IDLE;
                  req_r      <= 1'b0;
                  busy_r     <= 1'b0;
                  complete_r <= 1'b1;
                  err_r      <= 1'b1;
               end else if (ack_s) begin
                  // req stays high: the pointer access follows back-to-back.
                  addr_r  <= ADDR_W'(bus.dmem_dout);
                  we_r    <= ind_store_r;
                  state_r <= ind_store_r ? ST_WRITE : ST_READ;
               end
            end
            ST_READ, ST_WRITE: begin
               if (ack_s || timeout_s) begin
                  if (ack_s && (state_r == ST_READ)) begin
                     mem_out_r <= bus.dmem_dout;
                  end
                  state_r    <= ST_IDLE;
                  req_r      <= 1'b0;
                  we_r       <= 1'b0;
                  busy_r     <= 1'b0;
                  complete_r <= 1'b1;
                  err_r      <= timeout_s;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               req_r   <= 1'b0;
               we_r    <= 1'b0;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.dmem_req      = req_r;
   assign bus.dmem_we       = we_r;
   assign bus.dmem_addr     = addr_r;
   assign bus.dmem_din      = din_r;
   assign bus.mem_out       = mem_out_r;
   assign bus.complete_data = complete_r;
   assign bus.busy          = busy_r;
   assign bus.mem_state     = state_r;
   assign bus.mem_err       = err_r;
endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed steps plus randomized ops against a
// latency/memory model; the timeout step runs only when MEM_TIMEOUT_EN is defined.
module tb_mem_access_unit;
   localparam int TO = 4;
   localparam logic [3:0] OP_LD  = 4'b0010;
   localparam logic [3:0] OP_LDR = 4'b0110;
   localparam logic [3:0] OP_LDI = 4'b1010;
   localparam logic [3:0] OP_ST  = 4'b0011;
   localparam logic [3:0] OP_STR = 4'b0111;
   localparam logic [3:0] OP_STI = 4'b1011;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mem_access_if #(.ADDR_W(16), .DATA_W(16)) bus ();

   mem_access_unit #(.ADDR_W(16), .DATA_W(16), .TIMEOUT_CYCLES(TO)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [15:0] mem     [0:65535];
   logic [15:0] ref_mem [0:65535];
   int          wait_cfg = 0;
   bit          hang = 1'b0;
   int          wcnt = 0;
   int          n_cmp = 0;
   int          n_fail = 0;
   logic [15:0] exp_mem_out = 16'h0000;
   int          lat;
   logic        h_req [0:79];
   logic        h_we [0:79];
   logic        h_busy [0:79];
   logic [1:0]  h_state [0:79];
   logic [15:0] h_addr [0:79];
   logic [15:0] h_din [0:79];
   logic [3:0]  op_tab [0:7];

   // Memory responder: acks after wait_cfg wait cycles per request, never while hang is set.
   initial begin
      bus.dmem_ack  = 1'b0;
      bus.dmem_dout = 16'h0000;
      forever begin
         @(negedge clk);
         if (bus.dmem_ack === 1'b1) wcnt = 0;
         if (bus.dmem_req === 1'b1 && !hang) begin
            if (wcnt >= wait_cfg) begin
               bus.dmem_ack  = 1'b1;
               bus.dmem_dout = mem[bus.dmem_addr];
               if (bus.dmem_we === 1'b1) mem[bus.dmem_addr] = bus.dmem_din;
            end else begin
               bus.dmem_ack = 1'b0;
               wcnt++;
            end
         end else begin
            bus.dmem_ack = 1'b0;
            wcnt = 0;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, observed no finish, expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic preset(input logic [15:0] a, input logic [15:0] d);
      mem[a]     = d;
      ref_mem[a] = d;
   endtask

   // Issue one instruction at the current negedge and follow it until complete_data.
   task automatic do_op(input logic [3:0] op, input logic [15:0] addr, input logic [15:0] data,
                        input int w, input bit hang_en);
      int          exp_lat;
      int          lim;
      logic [15:0] ptr;
      logic [15:0] tgt;
      bit          is_st;
      logic        exp_err;
      logic        err_seen;
      is_st   = 1'b0;
      tgt     = addr;
      exp_err = 1'b0;
      if (hang_en) begin
         exp_lat = 1 + TO;
         exp_err = 1'b1;
      end else begin
         case (op)
            OP_LD, OP_LDR: begin
               exp_lat     = 2 + w;
               exp_mem_out = ref_mem[addr];
            end
            OP_ST, OP_STR: begin
               exp_lat      = 2 + w;
               is_st        = 1'b1;
               ref_mem[tgt] = data;
            end
            OP_LDI: begin
               exp_lat     = 3 + 2 * w;
               ptr         = ref_mem[addr];
               exp_mem_out = ref_mem[ptr];
            end
            OP_STI: begin
               exp_lat      = 3 + 2 * w;
               is_st        = 1'b1;
               tgt          = ref_mem[addr];
               ref_mem[tgt] = data;
            end
            default: exp_lat = 0;
         endcase
      end
      wait_cfg     = w;
      hang         = hang_en;
      bus.start    = 1'b1;
      bus.opcode   = op;
      bus.eff_addr = addr;
      bus.st_data  = data;
      h_state[0]   = bus.mem_state;
      lat          = 0;
      err_seen     = 1'b0;
      lim          = (exp_lat == 0) ? 6 : 70;
      for (int k = 1; k <= lim; k++) begin
         @(negedge clk);
         bus.start    = 1'b0;
         bus.eff_addr = 16'($urandom);
         bus.st_data  = 16'($urandom);
         h_req[k]     = bus.dmem_req;
         h_we[k]      = bus.dmem_we;
         h_busy[k]    = bus.busy;
         h_state[k]   = bus.mem_state;
         h_addr[k]    = bus.dmem_addr;
         h_din[k]     = bus.dmem_din;
         if (bus.complete_data === 1'b1) begin
            lat      = k;
            err_seen = bus.mem_err;
            break;
         end
      end
      hang = 1'b0;
      check("latency", lat, exp_lat);
      check("busy_after_start", {31'd0, h_busy[1]}, (exp_lat != 0) ? 32'd1 : 32'd0);
      if (exp_lat != 0 && lat != 0) begin
         check("mem_err", {31'd0, err_seen}, {31'd0, exp_err});
         check("req_dropped_at_done", {31'd0, h_req[lat]}, 32'd0);
      end else begin
         check("no_req_for_illegal", {31'd0, h_req[1]}, 32'd0);
      end
      check("mem_out", {16'd0, bus.mem_out}, {16'd0, exp_mem_out});
      if (is_st) check("store_data", {16'd0, mem[tgt]}, {16'd0, ref_mem[tgt]});
   endtask

   initial begin
      logic [15:0] v;
      bit          seen_done;
      op_tab[0] = OP_LD;  op_tab[1] = OP_LDR; op_tab[2] = OP_LDI; op_tab[3] = OP_ST;
      op_tab[4] = OP_STR; op_tab[5] = OP_STI; op_tab[6] = 4'b0000; op_tab[7] = 4'b1100;
      bus.start    = 1'b0;
      bus.opcode   = 4'b0000;
      bus.eff_addr = 16'h0000;
      bus.st_data  = 16'h0000;
      for (int i = 0; i < 65536; i++) begin
         v          = 16'($urandom);
         mem[i]     = v;
         ref_mem[i] = v;
      end

      // Reset values, then ten idle cycles.
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_req", {31'd0, bus.dmem_req}, 32'd0);
      check("rst_we", {31'd0, bus.dmem_we}, 32'd0);
      check("rst_addr", {16'd0, bus.dmem_addr}, 32'd0);
      check("rst_din", {16'd0, bus.dmem_din}, 32'd0);
      check("rst_mem_out", {16'd0, bus.mem_out}, 32'd0);
      check("rst_complete", {31'd0, bus.complete_data}, 32'd0);
      check("rst_busy", {31'd0, bus.busy}, 32'd0);
      check("rst_mem_err", {31'd0, bus.mem_err}, 32'd0);
      check("rst_state", {30'd0, bus.mem_state}, 32'd3);
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("idle_state", {30'd0, bus.mem_state}, 32'd3);
         check("idle_busy", {31'd0, bus.busy}, 32'd0);
         check("idle_req", {31'd0, bus.dmem_req}, 32'd0);
      end

      // LD, zero wait.
      preset(16'h3000, 16'hBEEF);
      do_op(OP_LD, 16'h3000, 16'h0000, 0, 1'b0);
      check("ld_req_t1", {31'd0, h_req[1]}, 32'd1);
      check("ld_we_t1", {31'd0, h_we[1]}, 32'd0);
      check("ld_addr_t1", {16'd0, h_addr[1]}, 32'h3000);
      check("ld_lat", lat, 32'd2);
      check("ld_mem_out", {16'd0, bus.mem_out}, 32'hBEEF);

      // STR with three wait cycles.
      do_op(OP_STR, 16'h4010, 16'h1234, 3, 1'b0);
      for (int k = 1; k <= 4; k++) begin
         check("str_req", {31'd0, h_req[k]}, 32'd1);
         check("str_we", {31'd0, h_we[k]}, 32'd1);
         check("str_addr", {16'd0, h_addr[k]}, 32'h4010);
         check("str_din", {16'd0, h_din[k]}, 32'h1234);
      end
      check("str_lat", lat, 32'd5);
      check("str_mem_out_kept", {16'd0, bus.mem_out}, 32'hBEEF);
      check("str_mem", {16'd0, mem[16'h4010]}, 32'h1234);

      // LDI through a pointer, zero wait.
      preset(16'h3002, 16'h5000);
      preset(16'h5000, 16'h00AA);
      do_op(OP_LDI, 16'h3002, 16'h0000, 0, 1'b0);
      check("ldi_state_t0", {30'd0, h_state[0]}, 32'd3);
      check("ldi_state_t1", {30'd0, h_state[1]}, 32'd1);
      check("ldi_state_t2", {30'd0, h_state[2]}, 32'd0);
      check("ldi_state_t3", {30'd0, h_state[3]}, 32'd3);
      check("ldi_addr2", {16'd0, h_addr[2]}, 32'h5000);
      check("ldi_lat", lat, 32'd3);
      check("ldi_mem_out", {16'd0, bus.mem_out}, 32'h00AA);

      // Back-to-back: each op is issued in the cycle its predecessor completes.
      do_op(OP_ST, 16'h3010, 16'h5A5A, 0, 1'b0);
      do_op(OP_LD, 16'h3010, 16'h0000, 1, 1'b0);

      // STI, ignored start while busy, reset during the WRITE phase.
      preset(16'h3004, 16'h6000);
      preset(16'h6000, 16'h7777);
      wait_cfg     = 2;
      seen_done    = 1'b0;
      bus.start    = 1'b1;
      bus.opcode   = OP_STI;
      bus.eff_addr = 16'h3004;
      bus.st_data  = 16'hCAFE;
      @(negedge clk);
      seen_done    = seen_done | bus.complete_data;
      check("sti_state_t1", {30'd0, bus.mem_state}, 32'd1);
      bus.opcode   = OP_LD;
      bus.eff_addr = 16'h3000;
      @(negedge clk);
      seen_done    = seen_done | bus.complete_data;
      bus.start    = 1'b0;
      check("busy_start_ignored_state", {30'd0, bus.mem_state}, 32'd1);
      check("busy_start_ignored_addr", {16'd0, bus.dmem_addr}, 32'h3004);
      @(negedge clk);
      seen_done    = seen_done | bus.complete_data;
      @(negedge clk);
      seen_done    = seen_done | bus.complete_data;
      check("sti_write_state", {30'd0, bus.mem_state}, 32'd2);
      check("sti_write_we", {31'd0, bus.dmem_we}, 32'd1);
      check("sti_write_addr", {16'd0, bus.dmem_addr}, 32'h6000);
      rst = 1'b1;
      @(negedge clk);
      seen_done    = seen_done | bus.complete_data;
      rst = 1'b0;
      check("rst_mid_req", {31'd0, bus.dmem_req}, 32'd0);
      check("rst_mid_state", {30'd0, bus.mem_state}, 32'd3);
      check("rst_mid_busy", {31'd0, bus.busy}, 32'd0);
      @(negedge clk);
      seen_done    = seen_done | bus.complete_data;
      check("rst_mid_no_complete", {31'd0, seen_done}, 32'd0);
      check("rst_mid_no_write", {16'd0, mem[16'h6000]}, 32'h7777);
      exp_mem_out = 16'h0000;
      check("rst_mid_mem_out", {16'd0, bus.mem_out}, 32'd0);

`ifdef MEM_TIMEOUT_EN
      // LD that is never acknowledged, then a normal LD.
      do_op(OP_LD, 16'h3100, 16'h0000, 0, 1'b1);
      check("timeout_lat", lat, 32'd5);
      do_op(OP_LD, 16'h3000, 16'h0000, 0, 1'b0);
`endif

      // Randomized instruction mix.
      for (int i = 0; i < 24; i++) begin
         do_op(op_tab[$urandom_range(0, 7)], 16'($urandom), 16'($urandom),
               int'($urandom_range(0, 3)), 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Data-memory access stage of the LC3 pipeline. It sits directly downstream of the controller/execute stage. It takes a memory instruction (LD, LDR, LDI, ST, STR, STI) with its computed effective address and store data, and sequences one or two data-memory transactions over a req/ack handshake. It returns the load result and the complete_data pulse, and exposes mem_state using the pipeline's existing encoding so the controller's stall logic can use it.

Parameters:
- ADDR_W, 16, address width.
- DATA_W, 16, data width.
- TIMEOUT_CYCLES, 64, maximum wait for dmem_ack per transaction; used only when MEM_TIMEOUT_EN is defined.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle strobe: memory instruction issued.
- opcode  in  4  IR_Exec[15:12] captured with start.
- eff_addr  in  ADDR_W  effective address from execute.
- st_data  in  DATA_W  store value (source register).
- dmem_req  out  1  memory request, level-held until ack.
- dmem_we  out  1  1 = write, 0 = read.
- dmem_addr  out  ADDR_W  memory address.
- dmem_din  out  DATA_W  write data.
- dmem_dout  in  DATA_W  read data, valid in the ack cycle.
- dmem_ack  in  1  transaction accepted/complete; ignored while dmem_req = 0.
- mem_out  out  DATA_W  last load result.
- complete_data  out  1  one-cycle pulse when the whole instruction finishes.
- busy  out  1  high in any state other than IDLE.
- mem_state  out  2  0 = READ, 1 = INDIRECT, 2 = WRITE, 3 = IDLE.
- mem_err  out  1  timeout pulse; tied 0 when MEM_TIMEOUT_EN is undefined.

Behaviour:
- All outputs are registered.
- Reset values: dmem_req = 0, dmem_we = 0, dmem_addr = 0, dmem_din = 0, mem_out = 0, complete_data = 0, busy = 0, mem_err = 0, mem_state = 3 (IDLE).
- Reset mid-transaction: on the next edge the FSM goes to IDLE and dmem_req drops. The in-flight op is discarded and complete_data is not pulsed.
- IDLE, start = 1, decode by opcode:
  - LD (0010) or LDR (0110) -> READ at eff_addr.
  - ST (0011) or STR (0111) -> WRITE at eff_addr with st_data.
  - LDI (1010) or STI (1011) -> INDIRECT at eff_addr.
  - Any other opcode: start is ignored and the FSM stays in IDLE.
- The opcode and st_data are latched at start.
- start while busy = 1 is ignored; there is no queueing.
- Request timing: dmem_req, dmem_addr, dmem_we and dmem_din are valid from the cycle after the state is entered. They are held stable until the cycle in which dmem_ack = 1.
- INDIRECT: read request. On ack, dmem_dout is latched as the pointer.
  - LDI -> READ at the pointer.
  - STI -> WRITE at the pointer.
  - The second request is asserted the cycle after the first ack; req stays high across the boundary.
- READ: on ack, mem_out <= dmem_dout, complete_data pulses next cycle, state -> IDLE.
- WRITE: on ack, complete_data pulses next cycle, state -> IDLE.
- Latency with a zero-wait memory (ack in the same cycle as req):
  - start at cycle T, req first high at T+1.
  - LD/ST: complete_data at T+2.
  - LDI/STI: complete_data at T+3.
  - Each wait cycle adds 1.
- Back-to-back: start in the same cycle complete_data is high is accepted, because the state is already IDLE.
- mem_out holds its value until the next READ completes. Stores never change it.

Optional Feature:
MEM_TIMEOUT_EN
- Defined: a per-transaction counter resets on each new request and increments while dmem_req = 1 and dmem_ack = 0.
  - When the count reaches TIMEOUT_CYCLES, the op aborts: dmem_req drops, mem_err pulses for 1 cycle, complete_data pulses in the same cycle so the pipeline unstalls, mem_out is unchanged, and state -> IDLE.
- Undefined: no counter is built, the block waits indefinitely, and mem_err is constant 0.

Test Plan:
- Reset, then no start: 10 cycles with mem_state = 3, busy = 0, dmem_req = 0 throughout.
- LD, eff_addr = 0x3000, memory returns 0xBEEF with 0 wait: req at T+1 with we = 0 and addr 0x3000; mem_out = 0xBEEF and complete_data = 1 at T+2.
- STR, eff_addr = 0x4010, st_data = 0x1234, ack after 3 wait cycles: dmem_we = 1, addr and din stable for 4 cycles; complete_data at T+5; mem_out unchanged.
- LDI, eff_addr = 0x3002, mem[0x3002] = 0x5000, mem[0x5000] = 0x00AA, 0 wait:
  - mem_state sequence 3, 1, 0, 3.
  - Second request addr = 0x5000.
  - mem_out = 0x00AA, complete_data at T+3.
- STI issued, second start (LD) pulsed while busy, rst asserted during WRITE:
  - Second start is ignored.
  - req drops the cycle after rst; no complete_data pulse; mem_state = 3.
- MEM_TIMEOUT_EN defined, TIMEOUT_CYCLES = 4, ack never asserted on an LD: mem_err and complete_data pulse together 4 cycles after req rises; next start is accepted normally.
